// File: rtl/dfp96_norm_seq.sv
// -----------------------------------------------------------------------------
// dfp96_norm_seq
// Multi-cycle normalizer for the 96-bit decimal floating-point add/sub path.
// Takes the unnormalized adder result (sign, biased exponent, 52-digit BCD
// significand, special flags). It removes leading zero digits a few per cycle
// and lowers the exponent to match. It then hands a 27-digit significand
// (precision + guard + round) and a sticky bit to the rounder.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_valid / i_ready        input handshake (i_ready is low while busy)
//   i_sign, i_exp, i_sig     unnormalized result; i_sig digit 51 is the MS digit
//   i_nan/i_qnan/i_snan/i_inf special flags, passed through untouched
//   o_valid / o_ready        output handshake; outputs hold until accepted
//   o_sign, o_exp, o_sig     normalized result, top 27 digits
//   o_sticky                 OR of the 25 discarded low digits
//   o_nan/o_qnan/o_snan/o_inf flags (o_inf also set on exponent overflow)
//   o_under                  exponent clamped at 0 with leading digit still zero
// -----------------------------------------------------------------------------
module dfp96_norm_seq #(
  parameter int          N             = 25,
  parameter int          SHIFT_PER_CYC = 4,
  parameter logic [11:0] EMAX          = 12'd3071
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic               i_sign,
  input  logic [11:0]        i_exp,
  input  logic [(N+1)*8-1:0] i_sig,
  input  logic               i_nan,
  input  logic               i_qnan,
  input  logic               i_snan,
  input  logic               i_inf,
  output logic               o_valid,
  input  logic               o_ready,
  output logic               o_sign,
  output logic [11:0]        o_exp,
  output logic [(N+2)*4-1:0] o_sig,
  output logic               o_sticky,
  output logic               o_nan,
  output logic               o_qnan,
  output logic               o_snan,
  output logic               o_inf,
  output logic               o_under
);

  localparam int SW = (N + 1) * 8;  // working significand width
  localparam int OW = (N + 2) * 4;  // delivered significand width

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  typedef struct packed {
    logic            sign;
    logic [11:0]     exp;
    logic [OW-1:0]   sig;
    logic            sticky;
    logic            nan;
    logic            qnan;
    logic            snan;
    logic            inf;
    logic            under;
  } res_t;

  state_e        state_q;
  logic          i_ready_q;
  logic          o_valid_q;
  res_t          res_q;

  // Captured operand; exp_cur_q carries one extra bit so i_exp+1 cannot wrap.
  logic          sign_q;
  logic [12:0]   exp_cur_q;
  logic [SW-1:0] sig_q;
  logic [3:0]    flags_q;  // {nan, qnan, snan, inf}

  // Per-cycle shift decision
  logic [3:0]    lz_d;
  logic          lz_stop;
  logic [3:0]    k_d;
  logic [SW-1:0] sig_shift_d;
  logic [12:0]   exp_shift_d;

  // DONE-entry decision
  logic          special;
  logic          sig_zero;
  logic          lead_nz;
  logic          done_d;
  res_t          res_d;

  assign special  = |flags_q;
  assign sig_zero = (sig_q == '0);
  assign lead_nz  = (sig_q[SW-1 -: 4] != 4'h0);

  // Leading zero digits, counted only as far as one cycle can shift; the
  // shift is further limited so the exponent never goes below zero.
  // NOTE: every combinational output gets a default before any branch or loop,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lz_d    = '0;
    lz_stop = 1'b0;
    for (int i = 0; i < SHIFT_PER_CYC; i++) begin
      if (!lz_stop && sig_q[SW-1-4*i -: 4] == 4'h0) lz_d = lz_d + 4'd1;
      else                                          lz_stop = 1'b1;
    end
    k_d = (exp_cur_q < {9'd0, lz_d}) ? exp_cur_q[3:0] : lz_d;
  end

  assign sig_shift_d = sig_q << {k_d, 2'b00};
  assign exp_shift_d = exp_cur_q - {9'd0, k_d};

  // Result selection in priority order: special, zero, normalized (with
  // overflow to infinity), clamped denormal; otherwise keep shifting.
  always_comb begin
    res_d      = '0;
    res_d.sign = sign_q;
    done_d     = 1'b1;
    if (special) begin
      // exp_cur_q still holds i_exp+1 here: specials leave SCAN on its first cycle.
      res_d.exp = exp_cur_q[11:0] - 12'd1;
      res_d.sig = sig_q[SW-1 -: OW];
      {res_d.nan, res_d.qnan, res_d.snan, res_d.inf} = flags_q;
    end else if (sig_zero) begin
      res_d.exp = '0;
    end else if (lead_nz && exp_cur_q > {1'b0, EMAX}) begin
      res_d.inf = 1'b1;
      res_d.exp = EMAX;
    end else if (lead_nz || exp_cur_q == '0) begin
      res_d.exp    = exp_cur_q[11:0];
      res_d.sig    = sig_q[SW-1 -: OW];
      res_d.sticky = |sig_q[SW-OW-1:0];
      res_d.under  = !lead_nz;
    end else begin
      done_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      i_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
      res_q     <= '0;
      sign_q    <= 1'b0;
      exp_cur_q <= '0;
      sig_q     <= '0;
      flags_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            sign_q    <= i_sign;
            exp_cur_q <= {1'b0, i_exp} + 13'd1;
            sig_q     <= i_sig;
            flags_q   <= {i_nan, i_qnan, i_snan, i_inf};
            i_ready_q <= 1'b0;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          if (done_d) begin
            res_q     <= res_d;
            o_valid_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            sig_q     <= sig_shift_d;
            exp_cur_q <= exp_shift_d;
          end
        end
        DONE: begin
          if (o_ready) begin
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_ready  = i_ready_q;
  assign o_valid  = o_valid_q;
  assign o_sign   = res_q.sign;
  assign o_exp    = res_q.exp;
  assign o_sig    = res_q.sig;
  assign o_sticky = res_q.sticky;
  assign o_nan    = res_q.nan;
  assign o_qnan   = res_q.qnan;
  assign o_snan   = res_q.snan;
  assign o_inf    = res_q.inf;
  assign o_under  = res_q.under;

endmodule

// File: doc/dfp96_norm_seq.md
Name: dfp96_norm_seq

Overview:
- Multi-cycle normalizer for the 96-bit decimal FP add/sub path.
- Consumes the unnormalized result of the adder/subtractor: sign, 12-bit exponent, 52-digit BCD significand and flags.
- Shifts leading zero digits out of the significand a few digits per cycle, adjusting the exponent to match.
- Delivers a 27-digit significand (25 precision + guard + round) plus sticky to the rounder over a valid/ready handshake.

Parameters:
- N, 25, precision in BCD digits; input significand is (N+1)*8 bits, output significand is (N+2)*4 bits.
- SHIFT_PER_CYC, 4, maximum number of digits shifted per SCAN cycle (1..8).
- EMAX, 12'd3071, largest finite biased exponent.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_valid  in  1  input result valid
- i_ready  out  1  block can accept
- i_sign  in  1  result sign
- i_exp  in  12  biased exponent of the unnormalized result
- i_sig  in  (N+1)*8  52-digit BCD significand; digit 51 is the MS digit (holds adder carry)
- i_nan, i_qnan, i_snan, i_inf  in  1 each  special flags
- o_valid  out  1  output valid
- o_ready  in  1  downstream accepts
- o_sign  out  1
- o_exp  out  12
- o_sig  out  (N+2)*4  top 27 digits after normalization
- o_sticky  out  1  OR of the 25 discarded low digits
- o_nan, o_qnan, o_snan, o_inf  out  1 each
- o_under  out  1  result is denormal (exponent clamped at 0 with leading digit zero)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, i_ready=1, o_valid=0, all other outputs 0. Reset mid-operation aborts the operation and discards captured data.
- IDLE: i_ready=1. On i_valid&i_ready, capture all inputs; set exp_cur=i_exp+1 (13-bit internal); go to SCAN.
- SCAN: i_ready=0. Each cycle evaluate, in priority order:
  - 1. Any special flag set: go to DONE; pass flags, sign, exp and sig through unshifted (sig truncated to top 27 digits).
  - 2. Significand all zero: go to DONE with o_exp=0, o_sig=0, o_sticky=0, o_under=0.
  - 3. Leading digit nonzero: go to DONE.
  - 4. exp_cur==0: go to DONE with o_under=1.
  - 5. Otherwise shift left by k=min(SHIFT_PER_CYC, leading-zero-digit count, exp_cur) digits; exp_cur -= k; stay in SCAN.
- Shift rules: shifts are whole digits (multiples of 4 bits); zeros fill from the right; no digit is lost from the low end before the sticky OR is taken.
- DONE entry, overflow: if exp_cur>EMAX and not special, force o_inf=1, o_sig=0, o_exp=EMAX.
- DONE entry, normal: o_exp=exp_cur[11:0], o_sig=sig[207:100], o_sticky=|sig[99:0]. Outputs are registered on entry.
- DONE: o_valid=1. All outputs hold stable until o_ready is sampled high; then o_valid=0 and state returns to IDLE on the same edge.
- i_ready=0 in DONE; no overlap of operations.
- Latency: o_valid rises 2+ceil(s/SHIFT_PER_CYC) cycles after the accepting edge, where s is the total digits shifted. Specials and zero take 2 cycles.
- Throughput: at most one result per latency+1 cycles. o_ready held high gives back-to-back operations with one IDLE cycle between.
- i_valid while not ready: ignored; upstream must hold its data.

Test Plan:
- Carry result: i_sig digit51=1, rest 0, i_exp=100 → o_valid 2 cycles after accept; o_exp=101, o_sig MS digit=1, o_sticky=0.
- Cancellation: leading zeros=7, i_exp=50, SHIFT_PER_CYC=4 → shifts of 4 then 3; o_valid at cycle 4; o_exp=44; leading digit nonzero.
- Denormal clamp: i_exp=2, 10 leading zeros → o_exp=0, o_under=1, significand shifted by 3 digits only.
- Zero and specials:
  - i_sig=0, i_exp=77 → o_exp=0, o_sig=0 at cycle 2.
  - i_nan=1 with sig=0x9… → flags and significand passed unshifted at cycle 2.
  - i_exp=3071 with a carry → o_inf=1, o_exp=3071, o_sig=0.
- Sticky: nonzero digit only in digit 3, no shift → o_sticky=1, o_sig=0 in low digits.
- Handshake and reset:
  - o_ready held low 5 cycles → outputs stable, i_ready=0; o_ready=1 → back to IDLE, next op accepted the following cycle.
  - rst pulsed during SCAN → o_valid=0, i_ready=1 next cycle, no stale output emerges.
